// File: rtl/lisa_qspi_arbiter_rr.sv
// lisa_qspi_arbiter_rr
//   N-client arbiter in front of the single QSPI controller. Client 0 (debug) can
//   optionally take strict priority, with a starvation guard that limits how many
//   back-to-back client-0 grants may occur while others wait. The remaining clients
//   (or all clients when priority is off) share the controller by rotating
//   round-robin. One transfer is in flight at a time, and a one-cycle turnaround
//   separates transfers.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   c_addr/c_wdata/c_wstrb          packed per-client request fields (client k at k*W +: W)
//   c_valid/c_ready_ack             per-client request and ready acknowledge
//   c_xfer_len/c_ce_ctrl            packed per-client transfer length and chip enables
//   c_rdata/c_ready/c_xfer_done     controller responses, routed to the active client only
//   dbg_custom_cmd/dbg_cmd_qw       client-0 custom command controls
//   addr..ce_ctrl, valid, ready_ack fields of the selected client, toward the controller
//   rdata/ready/xfer_done           controller responses
//   custom_spi_cmd/cmd_quad_write   client-0 command controls while client 0 is active
//   grant_id                        registered selected client
//   busy                            arbiter is in GRANT, XFER or TURN
module lisa_qspi_arbiter_rr #(
  parameter int unsigned N_CLIENTS    = 4,
  parameter int unsigned CHIP_SELECTS = 2,
  parameter int unsigned AW           = 24,
  parameter int unsigned DW           = 16,
  parameter int unsigned LEN_W        = 4,
  parameter int unsigned PRIO_CLIENT0 = 1,
  parameter int unsigned MAX_PRIO_RUN = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_CLIENTS*AW-1:0]           c_addr,
  input  logic [N_CLIENTS*DW-1:0]           c_wdata,
  input  logic [N_CLIENTS*2-1:0]            c_wstrb,
  input  logic [N_CLIENTS-1:0]              c_valid,
  input  logic [N_CLIENTS-1:0]              c_ready_ack,
  input  logic [N_CLIENTS*LEN_W-1:0]        c_xfer_len,
  input  logic [N_CLIENTS*CHIP_SELECTS-1:0] c_ce_ctrl,
  output logic [N_CLIENTS*DW-1:0]           c_rdata,
  output logic [N_CLIENTS-1:0]              c_ready,
  output logic [N_CLIENTS-1:0]              c_xfer_done,
  input  logic                              dbg_custom_cmd,
  input  logic [7:0]                        dbg_cmd_qw,
  output logic [AW-1:0]                     addr,
  output logic [DW-1:0]                     wdata,
  output logic [1:0]                        wstrb,
  output logic [LEN_W-1:0]                  xfer_len,
  output logic [CHIP_SELECTS-1:0]           ce_ctrl,
  output logic                              valid,
  output logic                              ready_ack,
  input  logic [DW-1:0]                     rdata,
  input  logic                              ready,
  input  logic                              xfer_done,
  output logic                              custom_spi_cmd,
  output logic [7:0]                        cmd_quad_write,
  output logic [$clog2(N_CLIENTS)-1:0]      grant_id,
  output logic                              busy
);

  localparam int unsigned SEL_W = $clog2(N_CLIENTS);
  localparam int unsigned RR_LO = (PRIO_CLIENT0 != 0) ? 1 : 0;
  localparam int unsigned RING  = N_CLIENTS - RR_LO;

  typedef enum logic [1:0] {StIdle, StGrant, StXfer, StTurn} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]       prio_cnt_q, prio_cnt_d;
  logic             valid_gate_q, valid_gate_d;

  logic             others_pending;
  logic             prio_blocked;
  logic             prio_win;
  logic             rr_found;
  logic [SEL_W-1:0] rr_win;
  logic             active;

  // Client index 'step' positions after ptr, wrapping N-1 back to the ring start.
  function automatic logic [SEL_W-1:0] ring_idx(logic [SEL_W-1:0] ptr, int unsigned step);
    int unsigned v;
    v = 32'(ptr) + step;
    if (v >= N_CLIENTS) v = v - RING;
    return SEL_W'(v);
  endfunction

  // Winner selection for the IDLE decision cycle
  always_comb begin
    others_pending = 1'b0;
    for (int k = 1; k < N_CLIENTS; k++) begin
      others_pending = others_pending | c_valid[k];
    end
    // Starvation guard: after MAX_PRIO_RUN back-to-back debug grants, yield once to the ring
    prio_blocked = (MAX_PRIO_RUN != 0) && (prio_cnt_q == 4'(MAX_PRIO_RUN)) && others_pending;
    prio_win     = (PRIO_CLIENT0 != 0) && c_valid[0] && !prio_blocked;

    rr_found = 1'b0;
    rr_win   = '0;
    for (int unsigned i = 0; i < RING; i++) begin
      if (!rr_found && c_valid[ring_idx(rr_ptr_q, i)]) begin
        rr_found = 1'b1;
        rr_win   = ring_idx(rr_ptr_q, i);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    prio_cnt_d   = prio_cnt_q;
    valid_gate_d = valid_gate_q;
    unique case (state_q)
      StIdle: begin
        if (prio_win) begin
          state_d      = StGrant;
          valid_gate_d = 1'b1;
          sel_d        = '0;
          // Count only runs that actually make someone else wait
          if (others_pending) begin
            prio_cnt_d = (prio_cnt_q == 4'hf) ? 4'hf : prio_cnt_q + 4'd1;
          end else begin
            prio_cnt_d = '0;
          end
        end else if (rr_found) begin
          state_d      = StGrant;
          valid_gate_d = 1'b1;
          sel_d        = rr_win;
          rr_ptr_d     = (rr_win == SEL_W'(N_CLIENTS - 1)) ? SEL_W'(RR_LO) : rr_win + 1'b1;
          prio_cnt_d   = '0;
        end
      end
      StGrant: begin
        // xfer_done takes precedence over a coincident first ready
        if (xfer_done) begin
          state_d      = StTurn;
          valid_gate_d = 1'b0;
        end else if (ready) begin
          state_d      = StXfer;
          valid_gate_d = 1'b0;
        end
      end
      StXfer: begin
        if (xfer_done) state_d = StTurn;
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      rr_ptr_q     <= SEL_W'(RR_LO);
      prio_cnt_q   <= '0;
      valid_gate_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
      prio_cnt_q   <= prio_cnt_d;
      valid_gate_q <= valid_gate_d;
    end
  end

  assign active   = (state_q == StGrant) || (state_q == StXfer);
  assign grant_id = sel_q;
  assign busy     = (state_q != StIdle);

  // Request-side mux and response-side routing
  always_comb begin
    addr           = '0;
    wdata          = '0;
    wstrb          = '0;
    xfer_len       = '0;
    ce_ctrl        = '0;
    valid          = 1'b0;
    ready_ack      = 1'b0;
    c_rdata        = '0;
    c_ready        = '0;
    c_xfer_done    = '0;
    custom_spi_cmd = 1'b0;
    cmd_quad_write = '0;
    for (int unsigned k = 0; k < N_CLIENTS; k++) begin
      if (sel_q == SEL_W'(k)) begin
        addr      = c_addr[k*AW +: AW];
        wdata     = c_wdata[k*DW +: DW];
        wstrb     = c_wstrb[k*2 +: 2];
        xfer_len  = c_xfer_len[k*LEN_W +: LEN_W];
        ce_ctrl   = c_ce_ctrl[k*CHIP_SELECTS +: CHIP_SELECTS];
        valid     = c_valid[k] & valid_gate_q;
        ready_ack = c_ready_ack[k];
        if (active) begin
          c_rdata[k*DW +: DW] = rdata;
          c_ready[k]          = ready;
          c_xfer_done[k]      = xfer_done;
        end
      end
    end
    if (active && (sel_q == '0)) begin
      custom_spi_cmd = dbg_custom_cmd;
      cmd_quad_write = dbg_cmd_qw;
    end
  end

endmodule

// File: tb/tb_lisa_qspi_arbiter_rr.sv
module tb_lisa_qspi_arbiter_rr;

  localparam int N     = 4;
  localparam int AW    = 24;
  localparam int DW    = 16;
  localparam int LW    = 4;
  localparam int CS    = 2;
  localparam int PRIO  = 1;
  localparam int MAXR  = 4;
  localparam int LO    = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*AW-1:0]   c_addr;
  logic [N*DW-1:0]   c_wdata;
  logic [N*2-1:0]    c_wstrb;
  logic [N-1:0]      c_valid;
  logic [N-1:0]      c_ready_ack;
  logic [N*LW-1:0]   c_xfer_len;
  logic [N*CS-1:0]   c_ce_ctrl;
  logic [N*DW-1:0]   c_rdata;
  logic [N-1:0]      c_ready;
  logic [N-1:0]      c_xfer_done;
  logic              dbg_custom_cmd;
  logic [7:0]        dbg_cmd_qw;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic [1:0]        wstrb;
  logic [LW-1:0]     xfer_len;
  logic [CS-1:0]     ce_ctrl;
  logic              valid;
  logic              ready_ack;
  logic [DW-1:0]     rdata;
  logic              ready;
  logic              xfer_done;
  logic              custom_spi_cmd;
  logic [7:0]        cmd_quad_write;
  logic [1:0]        grant_id;
  logic              busy;

  lisa_qspi_arbiter_rr #(
    .N_CLIENTS(N), .CHIP_SELECTS(CS), .AW(AW), .DW(DW), .LEN_W(LW),
    .PRIO_CLIENT0(PRIO), .MAX_PRIO_RUN(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
    .c_valid(c_valid), .c_ready_ack(c_ready_ack), .c_xfer_len(c_xfer_len),
    .c_ce_ctrl(c_ce_ctrl), .c_rdata(c_rdata), .c_ready(c_ready), .c_xfer_done(c_xfer_done),
    .dbg_custom_cmd(dbg_custom_cmd), .dbg_cmd_qw(dbg_cmd_qw), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .xfer_len(xfer_len), .ce_ctrl(ce_ctrl), .valid(valid),
    .ready_ack(ready_ack), .rdata(rdata), .ready(ready), .xfer_done(xfer_done),
    .custom_spi_cmd(custom_spi_cmd), .cmd_quad_write(cmd_quad_write),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sb_q[$];   // expected grant order, consumed by the monitor
  int exp_q[$];  // same order, consumed by the stimulus for routing checks
  int m_ptr;     // model: first ring client to consider
  int m_run;     // model: back-to-back debug grants while others wait

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: decide the next grant from the request set
  task automatic model_push(input logic [3:0] req);
    int w;
    int ring[$];
    bit others;
    if (req == 4'b0) return;
    others = |req[3:1];
    w = -1;
    if (PRIO != 0 && req[0] && !(MAXR != 0 && m_run == MAXR && others)) begin
      w = 0;
      m_run = others ? ((m_run < 15) ? m_run + 1 : 15) : 0;
    end else begin
      for (int k = LO; k < N; k++) ring.push_back(k);
      while (ring[0] != m_ptr) ring.push_back(ring.pop_front());
      for (int i = 0; i < ring.size(); i++) begin
        if (req[ring[i]]) begin
          w = ring[i];
          m_ptr = ring[(i + 1) % ring.size()];
          break;
        end
      end
      m_run = 0;
    end
    sb_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Monitor: a new grant is presented whenever busy rises
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev <= 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        chk("sb_has_entry", 64'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) chk("grant_id", grant_id, sb_q.pop_front());
      end
      busy_prev <= busy;
    end
  end

  // Serve one granted transfer as the controller; next_req is applied during TURN.
  task automatic run_xfer(input logic [3:0] next_req, input bit coincide, input int dir_exp);
    int  cur;
    bit  got;
    int  waited;
    got = 0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        got = 1;
        break;
      end
      waited++;
    end
    chk("valid_seen", got, 1);
    chk("grant_latency", waited, 0);
    cur = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
    if (dir_exp >= 0) chk("grant_order", grant_id, dir_exp);
    rdata = 16'($urandom);
    ready = 1'b1;
    xfer_done = coincide;
    #1;
    chk("c_ready_route", c_ready, 64'(1) << cur);
    chk("c_xfer_done_route", c_xfer_done, coincide ? (64'(1) << cur) : 64'(0));
    for (int k = 0; k < N; k++) begin
      chk("c_rdata_route", c_rdata[k*DW +: DW], (k == cur) ? rdata : 16'h0);
    end
    chk("addr_mux", addr, c_addr[cur*AW +: AW]);
    chk("len_mux", xfer_len, c_xfer_len[cur*LW +: LW]);
    chk("ready_ack_mux", ready_ack, c_ready_ack[cur]);
    chk("custom_cmd", custom_spi_cmd, (cur == 0) ? dbg_custom_cmd : 1'b0);
    chk("cmd_qw", cmd_quad_write, (cur == 0) ? dbg_cmd_qw : 8'h0);
    @(negedge clk);
    ready = 1'b0;
    xfer_done = 1'b0;
    #1;
    chk("valid_drop", valid, 0);
    if (!coincide) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xfer_done = 1'b1;
      #1;
      chk("xfer_done_route", c_xfer_done, 64'(1) << cur);
      @(negedge clk);
      xfer_done = 1'b0;
    end
    // Turnaround cycle: still busy, nothing routed
    chk("busy_turn", busy, 1);
    ready = 1'b1;
    xfer_done = 1'b1;
    #1;
    chk("turn_gated", {c_ready, c_xfer_done}, 0);
    c_valid = next_req;
    model_push(next_req);
    @(negedge clk);
    ready = 1'b0;
    xfer_done = 1'b0;
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  int ord_a[6]  = '{1, 2, 3, 1, 2, 3};
  int ord_b[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};

  initial begin
    bit got;
    rst_n = 1'b0;
    c_valid = '0;
    c_ready_ack = 4'($urandom);
    for (int k = 0; k < N; k++) begin
      c_addr[k*AW +: AW]   = 24'($urandom);
      c_wdata[k*DW +: DW]  = 16'($urandom);
      c_xfer_len[k*LW +: LW] = 4'($urandom);
    end
    c_wstrb = 8'($urandom);
    c_ce_ctrl = 8'($urandom);
    dbg_custom_cmd = 1'b1;
    dbg_cmd_qw = 8'h38;
    rdata = '0;
    ready = 1'b0;
    xfer_done = 1'b0;
    m_ptr = LO;
    m_run = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle: controller noise must not reach any client
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ready = 1'($urandom);
      xfer_done = 1'($urandom);
      rdata = 16'($urandom);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_valid", valid, 0);
      chk("idle_grant_id", grant_id, 0);
      chk("idle_c_ready", c_ready, 0);
      chk("idle_c_xfer_done", c_xfer_done, 0);
      chk("idle_c_rdata", c_rdata, 0);
      chk("idle_custom", {custom_spi_cmd, cmd_quad_write}, 0);
    end
    ready = 1'b0;
    xfer_done = 1'b0;

    // Ring-only requesters
    c_valid = 4'b1110;
    model_push(c_valid);
    for (int i = 0; i < 6; i++) run_xfer((i < 5) ? 4'b1110 : 4'b1111, 1'b0, ord_a[i]);

    // Debug priority with the run cap
    for (int i = 0; i < 10; i++) run_xfer((i < 9) ? 4'b1111 : 4'b0100, 1'b0, ord_b[i]);

    // Client 2 alone, done coincident with first ready
    run_xfer(4'b1000, 1'b1, 2);

    // Reset during client 3 transfer
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk("rst_valid_seen", got, 1);
    if (exp_q.size() != 0) chk("rst_grant3", exp_q.pop_front(), 3);
    ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_c_ready", c_ready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_grant_id", grant_id, 0);
    sb_q.delete();
    exp_q.delete();
    m_ptr = LO;
    m_run = 0;
    rst_n = 1'b1;
    ready = 1'b0;
    c_valid = 4'b1110;
    model_push(c_valid);
    run_xfer(4'($urandom_range(1, 15)), 1'b0, 1);

    // Randomized request patterns
    for (int i = 0; i < 40; i++) begin
      dbg_custom_cmd = 1'($urandom);
      dbg_cmd_qw = 8'($urandom);
      c_ready_ack = 4'($urandom);
      run_xfer((i < 39) ? 4'($urandom_range(1, 15)) : 4'b0, 1'($urandom_range(0, 3) == 0), -1);
    end
    repeat (3) @(negedge clk);
    chk("final_idle", busy, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
